proc_run_ctrl: RTL and testbench

Parametrised run controller that sits between the system clock and the processor core (PROCE_COMPLETE-class top) in both simulation and FPGA builds. It sequences core reset, gates execution through a clock enable, and supports three modes: free-run, single-step and bounded-run. It stops on halt, breakpoint or cycle limit and reports why. Its cycle counter and done flag give benches and on-board debug a deterministic end-of-run condition.

---
 rtl/proc_dbg_pkg.sv | 36 +++
 rtl/proc_run_ctrl_if.sv | 43 ++++
 rtl/sat_counter.sv | 41 ++++
 rtl/proc_run_ctrl.sv | 153 +++++++++++++++
 tb/tb_proc_run_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proc_dbg_pkg
// Purpose  : Shared encodings for the processor run controller: FSM state
//            codes, run-mode codes, stop-cause codes and a mode normaliser.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package proc_dbg_pkg;

  // Controller states
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CRST      = 3'd1;
  localparam logic [2:0] ST_RUN       = 3'd2;
  localparam logic [2:0] ST_STEP_IDLE = 3'd3;
  localparam logic [2:0] ST_STEP_GO   = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  // Run modes
  localparam logic [1:0] MODE_RUN     = 2'b00;
  localparam logic [1:0] MODE_STEP    = 2'b01;
  localparam logic [1:0] MODE_BOUNDED = 2'b10;

  // Stop causes reported on done_cause
  localparam logic [1:0] CAUSE_HALT  = 2'b00;
  localparam logic [1:0] CAUSE_BP    = 2'b01;
  localparam logic [1:0] CAUSE_LIMIT = 2'b10;
  localparam logic [1:0] CAUSE_ABORT = 2'b11;

  // The reserved mode code behaves exactly like free-run.
  function automatic logic [1:0] normalize_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_RUN : m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/proc_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : proc_run_ctrl_if
// Purpose  : Control/status bundle between a host (bench or debug logic)
//            and the run controller.
// Signals  : start, mode, step_req, cycle_limit, halt_in, pc_in, bp_en,
//            bp_addr, abort          (host -> controller)
//            cpu_rst, cpu_ce, running, done, done_cause, cycle_count
//                                    (controller -> host)
// Modports : master = host side, slave = controller side
// Revision : 1.0 - initial release
// ============================================================================
interface proc_run_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int PC_W  = 8
);
  logic             start;
  logic [1:0]       mode;
  logic             step_req;
  logic [CNT_W-1:0] cycle_limit;
  logic             halt_in;
  logic [PC_W-1:0]  pc_in;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic             abort;
  logic             cpu_rst;
  logic             cpu_ce;
  logic             running;
  logic             done;
  logic [1:0]       done_cause;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, mode, step_req, cycle_limit, halt_in, pc_in, bp_en, bp_addr, abort,
    input  cpu_rst, cpu_ce, running, done, done_cause, cycle_count
  );

  modport slave (
    input  start, mode, step_req, cycle_limit, halt_in, pc_in, bp_en, bp_addr, abort,
    output cpu_rst, cpu_ce, running, done, done_cause, cycle_count
  );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter with synchronous clear that sticks at all-ones.
// Ports    : clk, rst  - clock / sync active-high reset
//            clr       - clear to zero (wins over en)
//            en        - count enable
//            count     - current value
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule
`default_nettype wire

// File: rtl/proc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : proc_run_ctrl
// Purpose  : Run controller for the processor core. Sequences core reset,
//            gates execution with a clock enable, supports free-run,
//            single-step and bounded-run, and reports why a run stopped.
// Ports    : clk  - system clock
//            rst  - sync active-high reset
//            bus  - proc_run_ctrl_if.slave control/status bundle
// Revision : 1.0 - initial release
// ============================================================================
module proc_run_ctrl #(
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 32,
  parameter int PC_W       = 8
) (
  input  logic           clk,
  input  logic           rst,
  proc_run_ctrl_if.slave bus
);
  import proc_dbg_pkg::*;

  localparam int             RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [1:0]       cause_q, cause_d;
  logic [RC_W-1:0]  rcnt_q, rcnt_d;

  logic [CNT_W-1:0] cycle_count;
  logic             cnt_clr;
  logic             cpu_ce;
  logic             chk_active;
  logic             bp_hit;
  logic             lim_hit;
  logic             stop_hit;
  logic [1:0]       stop_cause;

  // Stop conditions are evaluated on the live inputs so the core is denied
  // its enable in the very cycle a condition is seen.
  always_comb begin
    chk_active = (state_q == ST_RUN) || (state_q == ST_STEP_IDLE);
    bp_hit     = bus.bp_en && (bus.pc_in == bus.bp_addr);
    lim_hit    = (mode_q == MODE_BOUNDED) && (cycle_count == limit_q);
    stop_hit   = chk_active && (bus.abort || bus.halt_in || bp_hit || lim_hit);
    if (bus.abort) begin
      stop_cause = CAUSE_ABORT;
    end else if (bus.halt_in) begin
      stop_cause = CAUSE_HALT;
    end else if (bp_hit) begin
      stop_cause = CAUSE_BP;
    end else begin
      stop_cause = CAUSE_LIMIT;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    limit_d = limit_q;
    cause_d = cause_q;
    rcnt_d  = rcnt_q;
    cnt_clr = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_CRST;
          mode_d  = normalize_mode(bus.mode);
          limit_d = bus.cycle_limit;
          cause_d = CAUSE_HALT;
          rcnt_d  = '0;
          cnt_clr = 1'b1;
        end
      end
      ST_CRST: begin
        if (bus.abort) begin
          state_d = ST_DONE;
          cause_d = CAUSE_ABORT;
        end else if (rcnt_q == RC_LAST) begin
          state_d = (mode_q == MODE_STEP) ? ST_STEP_IDLE : ST_RUN;
        end else begin
          rcnt_d = rcnt_q + RC_W'(1);
        end
      end
      ST_RUN: begin
        if (stop_hit) begin
          state_d = ST_DONE;
          cause_d = stop_cause;
        end
      end
      ST_STEP_IDLE: begin
        if (stop_hit) begin
          state_d = ST_DONE;
          cause_d = stop_cause;
        end else if (bus.step_req) begin
          state_d = ST_STEP_GO;
        end
      end
      ST_STEP_GO: begin
        // The granted cycle always completes; a step_req here is dropped.
        // An abort here is honoured once that cycle has executed.
        if (bus.abort) begin
          state_d = ST_DONE;
          cause_d = CAUSE_ABORT;
        end else begin
          state_d = ST_STEP_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_RUN;
      limit_q <= '0;
      cause_q <= CAUSE_HALT;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      limit_q <= limit_d;
      cause_q <= cause_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign cpu_ce = ((state_q == ST_RUN) && !stop_hit) || (state_q == ST_STEP_GO);

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cpu_ce),
    .count (cycle_count)
  );

  // DONE releases core reset so the frozen core state can be inspected.
  assign bus.cpu_rst     = (state_q == ST_IDLE) || (state_q == ST_CRST);
  assign bus.cpu_ce      = cpu_ce;
  assign bus.running     = (state_q == ST_CRST) || (state_q == ST_RUN) ||
                           (state_q == ST_STEP_IDLE) || (state_q == ST_STEP_GO);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.done_cause  = cause_q;
  assign bus.cycle_count = cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_proc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_run_ctrl
// Purpose  : Directed self-checking bench for proc_run_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_proc_run_ctrl;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  proc_run_ctrl_if #(.CNT_W(32), .PC_W(8)) bus ();

  proc_run_ctrl #(
    .RST_CYCLES (4),
    .CNT_W      (32),
    .PC_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called right after a negedge; returns one negedge later with CRST visible.
  task automatic do_start(input logic [1:0] m, input logic [31:0] lim);
    bus.start       = 1'b1;
    bus.mode        = m;
    bus.cycle_limit = lim;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst got=%0b exp=1", bus.cpu_rst); end
    checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL reset_cpu_ce got=%0b exp=0", bus.cpu_ce); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running got=%0b exp=0", bus.running); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
    checks++; if (bus.done_cause !== 2'b00) begin errors++; $display("FAIL reset_cause got=%0d exp=0", bus.done_cause); end
    checks++; if (bus.cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.cycle_count); end
  endtask

  task automatic test_abort();
    // Abort while idle must be ignored.
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_idle_done got=%0b exp=0", bus.done); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL abort_idle_running got=%0b exp=0", bus.running); end
    // Abort during core reset.
    do_start(2'b00, 32'd0);
    checks++; if (bus.cpu_rst !== 1'b1) begin errors++; $display("FAIL abort_crst_rst got=%0b exp=1", bus.cpu_rst); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL abort_crst_done got=%0b exp=1", bus.done); end
    checks++; if (bus.done_cause !== 2'b11) begin errors++; $display("FAIL abort_crst_cause got=%0d exp=3", bus.done_cause); end
    checks++; if (bus.cycle_count !== 32'd0) begin errors++; $display("FAIL abort_crst_count got=%0d exp=0", bus.cycle_count); end
    checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL abort_crst_ce got=%0b exp=0", bus.cpu_ce); end
  endtask

  task automatic test_bounded(input logic [31:0] lim, input int budget);
    int rst_n;
    int ce_n;
    int first;
    int exp_first;
    bit seen_done;
    exp_first = (lim == 0) ? -1 : 4;
    do_start(2'b10, lim);
    checks++; if (bus.cycle_count !== 32'd0) begin errors++; $display("FAIL bnd%0d_clr_count got=%0d exp=0", lim, bus.cycle_count); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL bnd%0d_clr_done got=%0b exp=0", lim, bus.done); end
    checks++; if (bus.done_cause !== 2'b00) begin errors++; $display("FAIL bnd%0d_clr_cause got=%0d exp=0", lim, bus.done_cause); end
    rst_n = 0; ce_n = 0; first = -1; seen_done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.done) begin
        seen_done = 1'b1;
        break;
      end
      if (bus.cpu_rst) rst_n++;
      if (bus.cpu_ce) begin
        if (first < 0) first = i;
        ce_n++;
      end
      @(negedge clk);
    end
    checks++; if (seen_done !== 1'b1) begin errors++; $display("FAIL bnd%0d_timeout got=%0b exp=1", lim, seen_done); end
    checks++; if (rst_n !== 4) begin errors++; $display("FAIL bnd%0d_rst_cycles got=%0d exp=4", lim, rst_n); end
    checks++; if (first !== exp_first) begin errors++; $display("FAIL bnd%0d_first_ce got=%0d exp=%0d", lim, first, exp_first); end
    checks++; if (ce_n !== int'(lim)) begin errors++; $display("FAIL bnd%0d_ce_cycles got=%0d exp=%0d", lim, ce_n, lim); end
    checks++; if (bus.done_cause !== 2'b10) begin errors++; $display("FAIL bnd%0d_cause got=%0d exp=2", lim, bus.done_cause); end
    checks++; if (bus.cycle_count !== lim) begin errors++; $display("FAIL bnd%0d_count got=%0d exp=%0d", lim, bus.cycle_count, lim); end
    checks++; if (bus.cpu_rst !== 1'b0) begin errors++; $display("FAIL bnd%0d_done_rst got=%0b exp=0", lim, bus.cpu_rst); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL bnd%0d_done_running got=%0b exp=0", lim, bus.running); end
  endtask

  task automatic test_halt();
    bit found;
    do_start(2'b00, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.cycle_count == 32'd37) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL halt_reach37 got=%0b exp=1", found); end
    checks++; if (bus.cpu_ce !== 1'b1) begin errors++; $display("FAIL halt_pre_ce got=%0b exp=1", bus.cpu_ce); end
    bus.halt_in = 1'b1;
    #1;
    checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL halt_ce_drop got=%0b exp=0", bus.cpu_ce); end
    @(negedge clk);
    bus.halt_in = 1'b0;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL halt_done got=%0b exp=1", bus.done); end
    checks++; if (bus.done_cause !== 2'b00) begin errors++; $display("FAIL halt_cause got=%0d exp=0", bus.done_cause); end
    checks++; if (bus.cycle_count !== 32'd37) begin errors++; $display("FAIL halt_count got=%0d exp=37", bus.cycle_count); end
  endtask

  task automatic test_step();
    int ce_total;
    bit ready;
    do_start(2'b01, 32'd0);
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.running && !bus.cpu_rst) begin
        ready = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL step_ready got=%0b exp=1", ready); end
    @(negedge clk);
    checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL step_idle_ce got=%0b exp=0", bus.cpu_ce); end
    ce_total = 0;
    for (int k = 0; k < 3; k++) begin
      bus.step_req = 1'b1;
      @(negedge clk);
      checks++; if (bus.cpu_ce !== 1'b1) begin errors++; $display("FAIL step%0d_go_ce got=%0b exp=1", k, bus.cpu_ce); end
      if (bus.cpu_ce) ce_total++;
      bus.step_req = 1'b1;           // extra request while STEP_GO
      @(negedge clk);
      if (bus.cpu_ce) ce_total++;
      bus.step_req = 1'b0;
      @(negedge clk);
      if (bus.cpu_ce) ce_total++;
    end
    checks++; if (ce_total !== 3) begin errors++; $display("FAIL step_ce_total got=%0d exp=3", ce_total); end
    checks++; if (bus.cycle_count !== 32'd3) begin errors++; $display("FAIL step_count got=%0d exp=3", bus.cycle_count); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL step_abort_done got=%0b exp=1", bus.done); end
    checks++; if (bus.done_cause !== 2'b11) begin errors++; $display("FAIL step_abort_cause got=%0d exp=3", bus.done_cause); end
  endtask

  task automatic test_bp(input bit with_halt, input logic [1:0] exp_cause);
    bit live;
    bus.bp_en   = 1'b1;
    bus.bp_addr = 8'h12;
    bus.pc_in   = 8'h00;
    do_start(2'b00, 32'd0);
    live = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cpu_ce) begin
        live = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (live !== 1'b1) begin errors++; $display("FAIL bp_h%0d_run got=%0b exp=1", with_halt, live); end
    @(negedge clk);
    bus.pc_in   = 8'h12;
    bus.halt_in = with_halt;
    #1;
    checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL bp_h%0d_ce got=%0b exp=0", with_halt, bus.cpu_ce); end
    @(negedge clk);
    bus.pc_in   = 8'h00;
    bus.halt_in = 1'b0;
    bus.bp_en   = 1'b0;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL bp_h%0d_done got=%0b exp=1", with_halt, bus.done); end
    checks++; if (bus.done_cause !== exp_cause) begin errors++; $display("FAIL bp_h%0d_cause got=%0d exp=%0d", with_halt, bus.done_cause, exp_cause); end
  endtask

  task automatic test_rst_mid_run();
    bit found;
    do_start(2'b00, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.cycle_count == 32'd50) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rst_reach50 got=%0b exp=1", found); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.cpu_rst !== 1'b1) begin errors++; $display("FAIL rstrun_cpu_rst got=%0b exp=1", bus.cpu_rst); end
    checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL rstrun_ce got=%0b exp=0", bus.cpu_ce); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL rstrun_running got=%0b exp=0", bus.running); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstrun_done got=%0b exp=0", bus.done); end
    checks++; if (bus.done_cause !== 2'b00) begin errors++; $display("FAIL rstrun_cause got=%0d exp=0", bus.done_cause); end
    checks++; if (bus.cycle_count !== 32'd0) begin errors++; $display("FAIL rstrun_count got=%0d exp=0", bus.cycle_count); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.mode        = 2'b00;
    bus.step_req    = 1'b0;
    bus.cycle_limit = '0;
    bus.halt_in     = 1'b0;
    bus.pc_in       = '0;
    bus.bp_en       = 1'b0;
    bus.bp_addr     = '0;
    bus.abort       = 1'b0;

    test_reset();
    test_abort();
    test_bounded(32'd200, 300);
    test_bounded(32'd200, 300);
    test_halt();
    test_step();
    test_bp(1'b1, 2'b00);
    test_bp(1'b0, 2'b01);
    test_bounded(32'd0, 40);
    test_bounded(32'd0, 40);
    test_rst_mid_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
